// File: rtl/pss_rom_sequencer_if.sv
// Control/stream bundle between the PSS ROM sequencer and its controller/downstream correlator.
// PSS_SEQ_PHASE_EN adds the iphase start-offset input.
interface pss_rom_sequencer_if #(
    parameter int pADDR_W = 11,
    parameter int pLOOP_W = 8
);
    logic               istart;
    logic               istop;
    logic [pADDR_W-1:0] ilast;
    logic [pLOOP_W-1:0] iloops;
    logic               irdy;
`ifdef PSS_SEQ_PHASE_EN
    logic [pADDR_W-1:0] iphase;
`endif
    logic [pADDR_W-1:0] oaddr;
    logic               orom_val;
    logic               odat_val;
    logic               osof;
    logic               oeof;
    logic               obusy;
    logic               odone;

    modport master (
        output istart, istop, ilast, iloops, irdy,
`ifdef PSS_SEQ_PHASE_EN
        output iphase,
`endif
        input  oaddr, orom_val, odat_val, osof, oeof, obusy, odone
    );

    modport slave (
        input  istart, istop, ilast, iloops, irdy,
`ifdef PSS_SEQ_PHASE_EN
        input  iphase,
`endif
        output oaddr, orom_val, odat_val, osof, oeof, obusy, odone
    );
endinterface

// File: rtl/pss_rom_sequencer.sv
// Address/valid sequencer in front of the 1-cycle-latency PSS reference ROM, with irdy back-pressure.
// Optional PSS_SEQ_PHASE_EN: sweeps start at iphase and end at iphase-1 (wrapping at ilast).
module pss_rom_sequencer #(
    parameter int pADDR_W = 11,
    parameter int pLOOP_W = 8
) (
    input logic iclk,
    input logic irst,
    pss_rom_sequencer_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t             r_state, w_nxt;
    logic [pADDR_W-1:0] r_addr, r_last, r_start, r_end;
    logic [pLOOP_W-1:0] r_loops, r_loop_cnt;
    logic               r_dat_val, r_sof, r_eof, r_done;
    logic               w_rom_val, w_sweep_end, w_final, w_accept, w_go;
    logic [pADDR_W-1:0] w_start, w_end;

`ifdef PSS_SEQ_PHASE_EN
    // Out-of-range phase falls back to a plain 0..ilast sweep.
    assign w_start = (bus.iphase > bus.ilast) ? '0 : bus.iphase;
    assign w_end   = (w_start == '0) ? bus.ilast : w_start - 1'b1;
`else
    assign w_start = '0;
    assign w_end   = bus.ilast;
`endif

    assign w_go        = bus.istart && !bus.istop;
    assign w_rom_val   = (r_state == S_RUN) && (!r_dat_val || bus.irdy);
    assign w_sweep_end = (r_addr == r_end);
    assign w_final     = (r_loops != '0) && (r_loop_cnt == r_loops - 1'b1);
    assign w_accept    = r_dat_val && bus.irdy;

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) r_state <= S_IDLE;
        else      r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_go) w_nxt = S_RUN;
            S_RUN: begin
                if (bus.istop)                               w_nxt = S_IDLE;
                else if (w_rom_val && w_sweep_end && w_final) w_nxt = S_DRAIN;
            end
            S_DRAIN: if (bus.istop || !r_dat_val || w_accept) w_nxt = S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            r_addr     <= '0;
            r_last     <= '0;
            r_start    <= '0;
            r_end      <= '0;
            r_loops    <= '0;
            r_loop_cnt <= '0;
            r_dat_val  <= 1'b0;
            r_sof      <= 1'b0;
            r_eof      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= (r_state == S_DRAIN) && w_accept && !bus.istop;

            if (r_state == S_IDLE) begin
                if (w_go) begin
                    r_last     <= bus.ilast;
                    r_loops    <= bus.iloops;
                    r_start    <= w_start;
                    r_end      <= w_end;
                    r_addr     <= w_start;
                    r_loop_cnt <= '0;
                end
            end else if (w_rom_val) begin
                if (!w_sweep_end) begin
                    r_addr <= (r_addr == r_last) ? '0 : r_addr + 1'b1;
                end else if (!w_final) begin
                    r_addr <= r_start;
                    // Continuous mode (iloops=0) keeps counting but must not wrap.
                    if (r_loop_cnt != '1) r_loop_cnt <= r_loop_cnt + 1'b1;
                end
            end

            if (bus.istop && r_state != S_IDLE) begin
                r_dat_val <= 1'b0;
                r_sof     <= 1'b0;
                r_eof     <= 1'b0;
            end else if (w_rom_val) begin
                r_dat_val <= 1'b1;
                r_sof     <= (r_addr == r_start);
                r_eof     <= w_sweep_end;
            end else if (bus.irdy) begin
                r_dat_val <= 1'b0;
            end
        end
    end

    assign bus.oaddr    = r_addr;
    assign bus.orom_val = w_rom_val;
    assign bus.odat_val = r_dat_val;
    assign bus.osof     = r_sof;
    assign bus.oeof     = r_eof;
    assign bus.obusy    = (r_state != S_IDLE);
    assign bus.odone    = r_done;
endmodule

// File: tb/tb_pss_rom_sequencer.sv
// Randomized bench for pss_rom_sequencer: a ROM model returns its address as data, and every
// accepted word is checked against a queue of expected (addr, sof, eof) built from the sweep rules.
module tb_pss_rom_sequencer;
    localparam int A = 11;
    localparam int L = 8;

    typedef struct packed {
        logic [A-1:0] addr;
        logic         sof;
        logic         eof;
    } wexp_t;

    logic iclk = 1'b0;
    logic irst = 1'b1;
    logic [A-1:0] rom_q = '0;
    int n_pass = 0;
    int n_total = 0;

    pss_rom_sequencer_if #(.pADDR_W(A), .pLOOP_W(L)) bus ();
    pss_rom_sequencer #(.pADDR_W(A), .pLOOP_W(L)) dut (.iclk(iclk), .irst(irst), .bus(bus));

    always #5 iclk = ~iclk;

    // ROM model: one-cycle latency, output held while enable is low.
    always @(posedge iclk) if (bus.orom_val) rom_q <= bus.oaddr;

    task automatic drive_idle();
        bus.istart = 1'b0;
        bus.istop  = 1'b0;
        bus.ilast  = '0;
        bus.iloops = '0;
        bus.irdy   = 1'b1;
`ifdef PSS_SEQ_PHASE_EN
        bus.iphase = '0;
`endif
    endtask

    task automatic test_reset();
        drive_idle();
        irst = 1'b1;
        repeat (2) @(negedge iclk);
        n_total++;
        if ({bus.oaddr, bus.orom_val, bus.odat_val, bus.osof, bus.oeof, bus.obusy, bus.odone} !== '0)
            $display("FAIL reset_state: got addr=%0d rv=%b dv=%b sof=%b eof=%b busy=%b done=%b, want all 0",
                     bus.oaddr, bus.orom_val, bus.odat_val, bus.osof, bus.oeof, bus.obusy, bus.odone);
        else n_pass++;
        irst = 1'b0;
        @(negedge iclk);
    endtask

    // mode: 0 irdy=1, 1 random irdy, 2 three-cycle stall while word 3 is presented.
    // stop_after: assert istop right as that many words are accepted (0 = run to completion).
    task automatic run_seq(input int last, input int loops, input int phase, input int mode,
                           input int stop_after, input bit poke);
        wexp_t q[$];
        wexp_t w;
        int s, e, a, sweeps, bound, acc, stalls;
        bit done_exp, fin, stopped;
        logic [A-1:0] frz;
        int ph;
`ifdef PSS_SEQ_PHASE_EN
        ph = phase;
`else
        ph = 0;
`endif
        s = (ph > last) ? 0 : ph;
        e = (s == 0) ? last : s - 1;
        sweeps = (loops != 0) ? loops : stop_after / (last + 1) + 2;
        for (int sw = 0; sw < sweeps; sw++) begin
            a = s;
            for (int k = 0; k <= last; k++) begin
                w.addr = a[A-1:0];
                w.sof  = (a == s);
                w.eof  = (a == e);
                q.push_back(w);
                a = (a == last) ? 0 : a + 1;
            end
        end
        bound = ((stop_after != 0) ? stop_after : q.size()) * 5 + 40;

        @(negedge iclk);
        bus.istart = 1'b1;
        bus.istop  = 1'b0;
        bus.ilast  = A'(last);
        bus.iloops = L'(loops);
        bus.irdy   = 1'b1;
`ifdef PSS_SEQ_PHASE_EN
        bus.iphase = A'(phase);
`endif
        acc = 0; stalls = 0; done_exp = 0; fin = 0; stopped = 0; frz = '0;
        for (int cyc = 0; cyc < bound && !fin; cyc++) begin
            @(negedge iclk);
            bus.istart = 1'b0;
            bus.istop  = 1'b0;
            if (poke && cyc == 5) begin
                bus.istart = 1'b1;
                bus.ilast  = A'(last + 3);
            end
            if (mode == 2 && acc == 2 && bus.odat_val && stalls < 3) begin
                bus.irdy = 1'b0;
                if (stalls == 0) frz = bus.oaddr;
                else begin
                    n_total++;
                    if (bus.oaddr !== frz || bus.odat_val !== 1'b1)
                        $display("FAIL stall_hold: addr=%0d dv=%b, want addr=%0d dv=1", bus.oaddr, bus.odat_val, frz);
                    else n_pass++;
                end
                stalls++;
            end else if (mode == 1) bus.irdy = ($urandom_range(0, 3) != 0);
            else bus.irdy = 1'b1;
            #1;
            n_total++;
            if (bus.odone !== done_exp) $display("FAIL odone: got %b want %b (word %0d)", bus.odone, done_exp, acc);
            else n_pass++;
            if (done_exp) begin
                n_total++;
                if (bus.obusy !== 1'b0) $display("FAIL busy_at_done: got %b want 0", bus.obusy);
                else n_pass++;
                fin = 1;
            end
            done_exp = 0;
            if (stopped) begin
                n_total++;
                if (bus.odat_val !== 1'b0 || bus.obusy !== 1'b0)
                    $display("FAIL after_stop: dv=%b busy=%b want 0 0", bus.odat_val, bus.obusy);
                else n_pass++;
                fin = 1;
            end else if (bus.odat_val && bus.irdy) begin
                n_total++;
                if (acc >= q.size())
                    $display("FAIL extra_word: word %0d beyond %0d expected", acc, q.size());
                else if (rom_q !== q[acc].addr || bus.osof !== q[acc].sof || bus.oeof !== q[acc].eof)
                    $display("FAIL word_%0d: got addr=%0d sof=%b eof=%b want addr=%0d sof=%b eof=%b",
                             acc, rom_q, bus.osof, bus.oeof, q[acc].addr, q[acc].sof, q[acc].eof);
                else n_pass++;
                acc++;
                if (stop_after != 0 && acc == stop_after) begin
                    bus.istop = 1'b1;
                    stopped = 1;
                end else if (stop_after == 0 && acc == q.size()) done_exp = 1;
            end
        end
        n_total++;
        if (!fin) $display("FAIL seq_timeout: accepted %0d words, no completion within %0d cycles", acc, bound);
        else n_pass++;
        // No late odone after completion or abort.
        repeat (3) begin
            @(negedge iclk);
            bus.istop = 1'b0;
            #1;
            n_total++;
            if (bus.odone !== 1'b0 || bus.obusy !== 1'b0)
                $display("FAIL idle_after_seq: done=%b busy=%b want 0 0", bus.odone, bus.obusy);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge iclk);
        bus.istart = 1'b1; bus.ilast = A'(100); bus.iloops = L'(1); bus.irdy = 1'b1;
        @(negedge iclk);
        bus.istart = 1'b0;
        repeat (10) @(negedge iclk);
        #2 irst = 1'b1;
        #1;
        n_total++;
        if ({bus.oaddr, bus.orom_val, bus.odat_val, bus.osof, bus.oeof, bus.obusy, bus.odone} !== '0)
            $display("FAIL reset_mid_run: got addr=%0d rv=%b dv=%b busy=%b done=%b, want all 0",
                     bus.oaddr, bus.orom_val, bus.odat_val, bus.obusy, bus.odone);
        else n_pass++;
        @(negedge iclk);
        irst = 1'b0;
        repeat (3) begin
            @(negedge iclk);
            #1;
            n_total++;
            if (bus.obusy !== 1'b0 || bus.odone !== 1'b0 || bus.orom_val !== 1'b0)
                $display("FAIL post_reset_idle: busy=%b done=%b rv=%b want 0 0 0", bus.obusy, bus.odone, bus.orom_val);
            else n_pass++;
        end
    endtask

    task automatic test_start_stop_idle();
        @(negedge iclk);
        bus.istart = 1'b1; bus.istop = 1'b1; bus.ilast = A'(5); bus.iloops = L'(1);
        @(negedge iclk);
        bus.istart = 1'b0; bus.istop = 1'b0;
        repeat (2) begin
            #1;
            n_total++;
            if (bus.obusy !== 1'b0 || bus.orom_val !== 1'b0)
                $display("FAIL start_stop_idle: busy=%b rv=%b want 0 0", bus.obusy, bus.orom_val);
            else n_pass++;
            @(negedge iclk);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++)
            run_seq($urandom_range(0, 9), $urandom_range(1, 3), $urandom_range(0, 12), 1, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_reset_mid_run();
        run_seq(3, 2, 0, 0, 0, 1'b0);      // basic two-sweep run, full throughput
        run_seq(3, 2, 0, 2, 0, 1'b0);      // stall on word 3
        run_seq(0, 3, 0, 1, 0, 1'b0);      // single-word sweeps
        run_seq(2047, 0, 0, 0, 2060, 1'b0); // full-range wrap, continuous, aborted mid-sweep
        run_seq(6, 0, 0, 1, 17, 1'b0);     // continuous with back-pressure, aborted
        test_start_stop_idle();
        run_seq(5, 2, 0, 1, 0, 1'b1);      // istart pulsed mid-run is ignored
`ifdef PSS_SEQ_PHASE_EN
        run_seq(3, 1, 2, 0, 0, 1'b0);
        run_seq(3, 1, 5, 0, 0, 1'b0);
        run_seq(7, 2, 7, 1, 0, 1'b0);
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
